// File: rtl/ac97_pcm_fifo_if.sv
// ac97_pcm_fifo_if
//  Register bus between the CPU-side master and the AC97 PCM FIFO.
//  Signals:
//    cyc_i, stb_i  bus cycle / strobe (block address already decoded by the parent)
//    we_i          1 = write
//    adr_i  [3:0]  register byte address
//    dat_i  [15:0] write data
//    dat_o  [15:0] registered read data
//    ack_o         bus acknowledge
//  The _i/_o suffixes are relative to the FIFO (slave) side.
interface ac97_pcm_fifo_if;
  logic        cyc_i;
  logic        stb_i;
  logic        we_i;
  logic [3:0]  adr_i;
  logic [15:0] dat_i;
  logic [15:0] dat_o;
  logic        ack_o;

  modport master (
    output cyc_i, stb_i, we_i, adr_i, dat_i,
    input  dat_o, ack_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, dat_i,
    output dat_o, ack_o
  );
endinterface

// File: rtl/ac97_pcm_fifo.sv
// ac97_pcm_fifo
//  Buffers stereo 16-bit PCM pairs written by the CPU and hands one
//  left/right pair to the AC97 wrapper on every AC-link frame strobe.
//  Reports fill level, overflow, underrun (with a saturating underrun
//  counter) and drives a level-sensitive low-water interrupt.
//  Ports:
//    clk_i    system clock
//    RESET    synchronous, active-high reset
//    bus      register bus (slave modport): LEFT 0x0, RIGHT 0x2, CTRL 0x4,
//             STATUS 0x6, UCNT 0x8
//    frame_i  one-cycle strobe per AC-link frame
//    left_o   left sample  {pcm, 2'b00}
//    right_o  right sample {pcm, 2'b00}
//    irq_o    low-water interrupt (irq_en & en & level <= LOWATER), registered
module ac97_pcm_fifo #(
  parameter int unsigned DEPTH_LOG2 = 6,
  parameter int unsigned LOWATER    = 16
) (
  input  logic                  clk_i,
  input  logic                  RESET,
  ac97_pcm_fifo_if.slave        bus,
  input  logic                  frame_i,
  output logic [17:0]           left_o,
  output logic [17:0]           right_o,
  output logic                  irq_o
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
  localparam logic [DEPTH_LOG2:0]   LVL_ONE = 1;

  typedef enum logic [3:0] {
    REG_LEFT   = 4'h0,
    REG_RIGHT  = 4'h2,
    REG_CTRL   = 4'h4,
    REG_STATUS = 4'h6,
    REG_UCNT   = 4'h8
  } reg_addr_e;

  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2:0]   level;

  logic        ack_q;
  logic [15:0] dat_q;
  logic        en;
  logic        irq_en;
  logic [15:0] hold;
  logic        ovf;
  logic        udf;
  logic [7:0]  ucnt;
  logic        irq_q;

  logic        cs;
  logic        act;
  logic        wr_left;
  logic        wr_right;
  logic        wr_ctrl;
  logic        wr_status;
  logic        wr_ucnt;
  logic        flush;
  logic        empty;
  logic        full;
  logic        pop;
  logic        underrun;
  logic        push;
  logic        drop;
  logic [15:0] rdata;

  always_comb begin
    cs        = bus.cyc_i & bus.stb_i;
    act       = cs & ~ack_q;
    wr_left   = 1'b0;
    wr_right  = 1'b0;
    wr_ctrl   = 1'b0;
    wr_status = 1'b0;
    wr_ucnt   = 1'b0;
    if (act && bus.we_i) begin
      case (bus.adr_i)
        REG_LEFT:   wr_left   = 1'b1;
        REG_RIGHT:  wr_right  = 1'b1;
        REG_CTRL:   wr_ctrl   = 1'b1;
        REG_STATUS: wr_status = 1'b1;
        REG_UCNT:   wr_ucnt   = 1'b1;
        default:    ;
      endcase
    end

    flush = wr_ctrl & bus.dat_i[1];
    empty = (level == '0);
    // level never exceeds DEPTH, so its MSB is set exactly when full.
    full  = level[DEPTH_LOG2];

    // Pop is evaluated before push: a coincident push into an empty FIFO
    // underruns this frame, and a push into a full FIFO uses the freed slot.
    pop      = frame_i & en & ~empty & ~flush;
    underrun = frame_i & en & empty & ~flush;
    push     = wr_right & ~flush & (~full | pop);
    drop     = wr_right & full & ~pop;
  end

  always_comb begin
    rdata = '0;
    case (bus.adr_i)
      REG_LEFT:   rdata = hold;
      REG_CTRL:   rdata = {13'd0, irq_en, 1'b0, en};
      REG_STATUS: begin
        rdata[15]           = ovf;
        rdata[14]           = udf;
        rdata[DEPTH_LOG2:0] = level;
      end
      REG_UCNT:   rdata = {8'h00, ucnt};
      default:    rdata = '0;
    endcase
  end

  // FIFO storage is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= {hold, bus.dat_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (RESET) begin
      ack_q   <= 1'b0;
      dat_q   <= '0;
      en      <= 1'b0;
      irq_en  <= 1'b0;
      hold    <= '0;
      ovf     <= 1'b0;
      udf     <= 1'b0;
      ucnt    <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      level   <= '0;
      left_o  <= '0;
      right_o <= '0;
      irq_q   <= 1'b0;
    end else begin
      ack_q <= act;

      if (!cs) begin
        dat_q <= '0;
      end else if (act) begin
        dat_q <= rdata;
      end

      if (wr_left) begin
        hold <= bus.dat_i;
      end

      if (wr_ctrl) begin
        en     <= bus.dat_i[0];
        irq_en <= bus.dat_i[2];
      end

      if (drop) begin
        ovf <= 1'b1;
      end else if (wr_status && bus.dat_i[15]) begin
        ovf <= 1'b0;
      end

      if (underrun) begin
        udf <= 1'b1;
      end else if (wr_status && bus.dat_i[14]) begin
        udf <= 1'b0;
      end

      if (wr_ucnt) begin
        ucnt <= '0;
      end else if (underrun && ucnt != 8'hFF) begin
        ucnt <= ucnt + 8'd1;
      end

      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_ONE;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_ONE;
        end
        case ({push, pop})
          2'b10:   level <= level + LVL_ONE;
          2'b01:   level <= level - LVL_ONE;
          default: ;
        endcase
      end

      // On underrun the outputs simply keep their previous pair.
      if (flush) begin
        left_o  <= '0;
        right_o <= '0;
      end else if (pop) begin
        left_o  <= {mem[rd_ptr][31:16], 2'b00};
        right_o <= {mem[rd_ptr][15:0], 2'b00};
      end else if (frame_i && !en) begin
        left_o  <= '0;
        right_o <= '0;
      end

      irq_q <= irq_en & en & (32'(level) <= LOWATER);
    end
  end

  assign bus.ack_o = ack_q;
  assign bus.dat_o = dat_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_ac97_pcm_fifo.sv
// tb_ac97_pcm_fifo
//  Scoreboard bench: stimulus updates a queue-based reference model and
//  pushes expected bus read data / frame samples; independent monitors
//  compare whenever the DUT acknowledges a bus access or a frame completes.
module tb_ac97_pcm_fifo;
  localparam int DL    = 6;
  localparam int DEPTH = 64;
  localparam int LW    = 16;

  logic        clk_i = 1'b0;
  logic        RESET;
  logic        frame_i;
  logic [17:0] left_o;
  logic [17:0] right_o;
  logic        irq_o;

  ac97_pcm_fifo_if bus_if ();

  ac97_pcm_fifo #(.DEPTH_LOG2(DL), .LOWATER(LW)) dut (
    .clk_i   (clk_i),
    .RESET   (RESET),
    .bus     (bus_if),
    .frame_i (frame_i),
    .left_o  (left_o),
    .right_o (right_o),
    .irq_o   (irq_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          is_read;
    logic [3:0]  adr;
    logic [15:0] val;
  } bus_exp_t;

  typedef struct {
    logic [17:0] l;
    logic [17:0] r;
  } smp_t;

  bus_exp_t bq[$];
  smp_t     sq[$];

  // Reference model
  logic [31:0] mq[$];
  bit          m_en, m_irqen, m_ovf, m_udf;
  logic [15:0] m_hold;
  int          m_ucnt;
  logic [17:0] m_l, m_r;

  task automatic m_reset();
    mq.delete();
    m_en = 0; m_irqen = 0; m_ovf = 0; m_udf = 0;
    m_hold = '0; m_ucnt = 0; m_l = '0; m_r = '0;
  endtask

  function automatic logic [15:0] m_read(input logic [3:0] a);
    case (a)
      4'h0: return m_hold;
      4'h4: return {13'd0, m_irqen, 1'b0, m_en};
      4'h6: return {m_ovf, m_udf, 7'd0, 7'(mq.size())};
      4'h8: return {8'h00, 8'(m_ucnt)};
      default: return 16'h0000;
    endcase
  endfunction

  function automatic bit m_irq();
    return m_irqen && m_en && (mq.size() <= LW);
  endfunction

  task automatic m_frame();
    logic [31:0] p;
    if (!m_en) begin
      m_l = '0; m_r = '0;
    end else if (mq.size() == 0) begin
      m_udf = 1;
      if (m_ucnt < 255) m_ucnt++;
    end else begin
      p = mq.pop_front();
      m_l = {p[31:16], 2'b00};
      m_r = {p[15:0], 2'b00};
    end
    sq.push_back('{m_l, m_r});
  endtask

  task automatic m_write(input logic [3:0] a, input logic [15:0] d);
    case (a)
      4'h0: m_hold = d;
      4'h2: if (mq.size() < DEPTH) mq.push_back({m_hold, d}); else m_ovf = 1;
      4'h4: begin
        m_en = d[0]; m_irqen = d[2];
        if (d[1]) begin mq.delete(); m_l = '0; m_r = '0; end
      end
      4'h6: begin
        if (d[15]) m_ovf = 0;
        if (d[14]) m_udf = 0;
      end
      4'h8: m_ucnt = 0;
      default: ;
    endcase
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // All stimulus tasks start and end at posedge+#1.
  task automatic bus(input bit we, input logic [3:0] a, input logic [15:0] d, input bit fr);
    bus_exp_t e;
    int n;
    e.is_read = !we;
    e.adr     = a;
    e.val     = we ? 16'h0000 : m_read(a);
    if (fr) m_frame();
    if (we) m_write(a, d);
    bq.push_back(e);
    bus_if.cyc_i = 1; bus_if.stb_i = 1; bus_if.we_i = we;
    bus_if.adr_i = a; bus_if.dat_i = d; frame_i = fr;
    n = 0;
    do begin
      @(posedge clk_i); #1;
      frame_i = 0;
      n++;
    end while (!bus_if.ack_o && n < 8);
    if (!bus_if.ack_o) begin
      errors++; checks++;
      $display("FAIL bus_ack_timeout: got ack=0 expected ack=1 adr=%h", a);
    end
    bus_if.cyc_i = 0; bus_if.stb_i = 0; bus_if.we_i = 0;
    @(posedge clk_i); #1;
  endtask

  task automatic frame();
    m_frame();
    frame_i = 1;
    @(posedge clk_i); #1;
    frame_i = 0;
  endtask

  task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
    bus(1, 4'h0, l, 0);
    bus(1, 4'h2, r, 0);
  endtask

  task automatic do_reset();
    RESET = 1;
    bus_if.cyc_i = 0; bus_if.stb_i = 0; bus_if.we_i = 0;
    bus_if.adr_i = '0; bus_if.dat_i = '0; frame_i = 0;
    repeat (3) @(posedge clk_i);
    #1 RESET = 0;
    m_reset();
  endtask

  task automatic summary();
    $display("Result: errors=%0d of %0d checks", errors, checks);
  endtask

  // Monitors
  logic fr_q = 1'b0;
  always @(posedge clk_i) fr_q <= frame_i & ~RESET;

  always @(negedge clk_i) begin
    bus_exp_t e;
    smp_t     s;
    if (bus_if.ack_o) begin
      if (bq.size() == 0) begin
        errors++; checks++;
        $display("FAIL bus_unexpected_ack: got ack=1 expected no access");
      end else begin
        e = bq.pop_front();
        if (e.is_read) begin
          checks++;
          if (bus_if.dat_o !== e.val) begin
            errors++;
            $display("FAIL bus_read adr=%h: got %h expected %h", e.adr, bus_if.dat_o, e.val);
          end
        end
      end
    end
    if (fr_q) begin
      if (sq.size() == 0) begin
        errors++; checks++;
        $display("FAIL frame_unexpected: got frame expected none");
      end else begin
        s = sq.pop_front();
        checks++;
        if (left_o !== s.l || right_o !== s.r) begin
          errors++;
          $display("FAIL frame_sample: got %h/%h expected %h/%h", left_o, right_o, s.l, s.r);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    summary();
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    do_reset();

    // Reset state
    chk("rst_left", 32'(left_o), 0);
    chk("rst_right", 32'(right_o), 0);
    chk("rst_irq", 32'(irq_o), 0);
    chk("rst_ack", 32'(bus_if.ack_o), 0);
    chk("rst_dat", 32'(bus_if.dat_o), 0);

    // Basic push/pop
    bus(1, 4'h4, 16'h0005, 0);
    push_pair(16'h1234, 16'hABCD);
    frame();
    chk("t1_left", 32'(left_o), 32'h048D0);
    chk("t1_right", 32'(right_o), 32'h2AF34);
    bus(0, 4'h6, 0, 0);
    bus(0, 4'h4, 0, 0);

    // Fill to full, overflow, drain in order
    bus(1, 4'h4, 16'h0000, 0);
    for (int i = 0; i < DEPTH + 1; i++) push_pair(16'($urandom), 16'($urandom));
    bus(0, 4'h6, 0, 0);
    bus(1, 4'h4, 16'h0001, 0);
    for (int i = 0; i < DEPTH; i++) frame();
    bus(0, 4'h6, 0, 0);

    // Underrun
    repeat (3) frame();
    bus(0, 4'h8, 0, 0);
    bus(0, 4'h6, 0, 0);
    bus(1, 4'h6, 16'h4000, 0);
    bus(0, 4'h6, 0, 0);

    // Push coincident with pop while full
    bus(1, 4'h6, 16'hC000, 0);
    for (int i = 0; i < DEPTH; i++) push_pair(16'($urandom), 16'($urandom));
    bus(1, 4'h0, 16'h5A5A, 0);
    bus(1, 4'h2, 16'hC3C3, 1);
    bus(0, 4'h6, 0, 0);
    for (int i = 0; i < DEPTH; i++) frame();
    chk("t4_last_left", 32'(left_o), 32'h16968);
    chk("t4_last_right", 32'(right_o), 32'h30F0C);
    bus(0, 4'h6, 0, 0);

    // Low-water interrupt and flush
    bus(1, 4'h4, 16'h0005, 0);
    for (int i = 0; i < LW + 1; i++) push_pair(16'($urandom), 16'($urandom));
    @(posedge clk_i); #1;
    chk("t5_irq_lvl17", 32'(irq_o), 0);
    frame();
    chk("t5_irq_same_cycle", 32'(irq_o), 0);
    @(posedge clk_i); #1;
    chk("t5_irq_lvl16", 32'(irq_o), 1);
    bus(1, 4'h4, 16'h0007, 0);
    chk("t5_flush_left", 32'(left_o), 0);
    chk("t5_flush_right", 32'(right_o), 0);
    bus(0, 4'h6, 0, 0);

    // Reset in the middle of a RIGHT write
    bus(1, 4'h4, 16'h0001, 0);
    push_pair(16'h7777, 16'h8888);
    push_pair(16'h1111, 16'h2222);
    frame();
    bus(1, 4'h0, 16'h3333, 0);
    bus_if.cyc_i = 1; bus_if.stb_i = 1; bus_if.we_i = 1;
    bus_if.adr_i = 4'h2; bus_if.dat_i = 16'h4444; RESET = 1;
    @(posedge clk_i); #1;
    RESET = 0;
    bus_if.cyc_i = 0; bus_if.stb_i = 0; bus_if.we_i = 0;
    m_reset();
    chk("t6_ack", 32'(bus_if.ack_o), 0);
    chk("t6_left", 32'(left_o), 0);
    chk("t6_right", 32'(right_o), 0);
    chk("t6_irq", 32'(irq_o), 0);
    chk("t6_dat", 32'(bus_if.dat_o), 0);
    @(posedge clk_i); #1;
    bus(0, 4'h6, 0, 0);
    bus(0, 4'h0, 0, 0);

    // Randomized traffic
    bus(1, 4'h4, 16'h0005, 0);
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 35)      push_pair(16'($urandom), 16'($urandom));
      else if (r < 60) frame();
      else if (r < 65) begin
        bus(1, 4'h0, 16'($urandom), 0);
        bus(1, 4'h2, 16'($urandom), 1);
      end
      else if (r < 72) bus(0, 4'h6, 0, 0);
      else if (r < 76) bus(0, 4'h8, 0, 0);
      else if (r < 80) bus(0, 4'h0, 0, 0);
      else if (r < 83) bus(0, 4'h4, 0, 0);
      else if (r < 86) bus(1, 4'h6, 16'($urandom), 0);
      else if (r < 88) bus(1, 4'h8, 16'($urandom), 0);
      else if (r < 93) bus(1, 4'h4, {13'd0, 1'($urandom), 1'b0, ($urandom_range(0, 3) != 0)}, 0);
      else if (r < 95) bus(1, 4'h4, {13'd0, 1'($urandom), 2'b11}, 0);
      else begin
        @(posedge clk_i); #1;
        chk("rand_irq", 32'(irq_o), 32'(m_irq()));
      end
    end
    bus(0, 4'h6, 0, 0);
    bus(0, 4'h8, 0, 0);

    repeat (4) @(posedge clk_i);
    #1;
    chk("bus_queue_drained", 32'(bq.size()), 0);
    chk("frame_queue_drained", 32'(sq.size()), 0);
    summary();
    $finish;
  end
endmodule
